// File: rtl/counter_scan_pkg.sv
// Shared types and constants for the counter scan controller.
// Holds the scan FSM state encoding, record header magic and default read latency.
package counter_scan_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [2:0] {
        StIdle,
        StSel,
        StOpen,
        StCapt,
        StHdr,
        StData,
        StTime,
        StDone
    } state_e;

    localparam logic [7:0]  HDR_MAGIC    = 8'hC5;
    localparam int unsigned READ_LAT_DEF = 4;

    // Header word: magic, scan sequence, channel index.
    function automatic word_t hdr_word(input logic [7:0] seq, input logic [3:0] ch);
        return {HDR_MAGIC, seq, 4'h0, ch, 8'h00};
    endfunction

endpackage

// File: rtl/counter_scan_ctrl_if.sv
// Record output stream of the counter scan controller (valid/ready handshake).
// The controller drives the master side, the record sink the slave side.
interface counter_scan_ctrl_if;
    import counter_scan_pkg::*;

    word_t out_data;
    logic  out_valid;
    logic  out_ready;
    logic  out_last;

    modport master (
        output out_data,
        output out_valid,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        input  out_last,
        output out_ready
    );

endinterface

// File: rtl/counter_scan_timer.sv
// Periodic scan trigger: one tick every scan_period cycles while enabled.
// Held at zero whenever auto_en is low or scan_period is zero.
module counter_scan_timer (
    input  logic        clk,
    input  logic        res_n,
    input  logic        auto_en,
    input  logic [31:0] scan_period,
    output logic        tick
);

    logic [31:0] cnt_q;
    logic [31:0] cnt_inc;
    logic        tick_q;
    logic        run;

    assign run     = auto_en && (scan_period != 32'd0);
    assign cnt_inc = cnt_q + 32'd1;

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else if (!run) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else if (cnt_inc >= scan_period) begin
            cnt_q  <= '0;
            tick_q <= 1'b1;
        end else begin
            cnt_q  <= cnt_inc;
            tick_q <= 1'b0;
        end
    end

    // Gated so a tick cannot leak out in the cycle the timer is disabled.
    assign tick = tick_q && run;

endmodule

// File: rtl/counter_scan_ctrl.sv
// Scans the masked counter channels: opens each channel's read latch, snapshots
// its count and live time, and streams a header/data/time record per channel.
module counter_scan_ctrl
    import counter_scan_pkg::*;
#(
    parameter int unsigned N_CH     = 4,
    parameter int unsigned READ_LAT = READ_LAT_DEF
) (
    input  logic                 clk,
    input  logic                 res_n,
    input  logic                 scan_start,
    input  logic                 auto_en,
    input  logic [31:0]          scan_period,
    input  logic [N_CH-1:0]      ch_mask,
    output logic [N_CH-1:0]      read_open,
    input  logic [N_CH*32-1:0]   data_ex,
    input  logic [N_CH*32-1:0]   counter_time_ex,
    counter_scan_ctrl_if.master  st,
    output logic                 busy,
    output logic [15:0]          scan_count,
    output logic                 overrun
);

    localparam logic [15:0] LatLast = 16'(READ_LAT - 1);

    state_e          state_q;
    state_e          state_d;
    logic [N_CH-1:0] pending_q;
    logic [3:0]      ch_q;
    logic [15:0]     lat_q;
    word_t           snap_data_q;
    word_t           snap_time_q;
    logic [15:0]     count_q;
    logic [7:0]      seq_q;
    logic            ovr_q;

    logic            tick;
    logic            trig;
    logic [3:0]      lowest_ch;
    logic [N_CH-1:0] lowest_onehot;
    logic [N_CH-1:0] ch_onehot;
    word_t           sel_data;
    word_t           sel_time;

    counter_scan_timer u_timer (
        .clk         (clk),
        .res_n       (res_n),
        .auto_en     (auto_en),
        .scan_period (scan_period),
        .tick        (tick)
    );

    assign trig = scan_start || tick;

    // Lowest-index channel still waiting to be served in this scan.
    always_comb begin
        lowest_ch     = 4'd0;
        lowest_onehot = '0;
        for (int i = int'(N_CH) - 1; i >= 0; i--) begin
            if (pending_q[i]) begin
                lowest_ch        = 4'(i);
                lowest_onehot    = '0;
                lowest_onehot[i] = 1'b1;
            end
        end
    end

    always_comb begin
        ch_onehot = '0;
        sel_data  = '0;
        sel_time  = '0;
        for (int i = 0; i < int'(N_CH); i++) begin
            if (ch_q == 4'(i)) begin
                ch_onehot[i] = 1'b1;
                sel_data     = data_ex[32*i +: 32];
                sel_time     = counter_time_ex[32*i +: 32];
            end
        end
    end

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (trig && (ch_mask != '0)) begin
                    state_d = StSel;
                end
            end
            StSel: state_d = StOpen;
            StOpen: begin
                if (lat_q == LatLast) begin
                    state_d = StCapt;
                end
            end
            StCapt: state_d = StHdr;
            StHdr: begin
                if (st.out_ready) begin
                    state_d = StData;
                end
            end
            StData: begin
                if (st.out_ready) begin
                    state_d = StTime;
                end
            end
            StTime: begin
                if (st.out_ready) begin
                    state_d = (pending_q != '0) ? StSel : StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            pending_q   <= '0;
            ch_q        <= 4'd0;
            lat_q       <= 16'd0;
            snap_data_q <= '0;
            snap_time_q <= '0;
            count_q     <= 16'd0;
            seq_q       <= 8'd0;
            ovr_q       <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    // Mask is latched here so later edits only affect the next scan.
                    if (trig && (ch_mask != '0)) begin
                        pending_q <= ch_mask;
                    end
                end
                StSel: begin
                    ch_q      <= lowest_ch;
                    pending_q <= pending_q & ~lowest_onehot;
                    lat_q     <= 16'd0;
                end
                StOpen: lat_q <= lat_q + 16'd1;
                StCapt: begin
                    snap_data_q <= sel_data;
                    snap_time_q <= sel_time;
                end
                StDone: begin
                    count_q <= count_q + 16'd1;
                    seq_q   <= seq_q + 8'd1;
                end
                default: ;
            endcase
            if (trig && (state_q != StIdle)) begin
                ovr_q <= 1'b1;
            end
        end
    end

    always_comb begin
        read_open    = '0;
        st.out_valid = 1'b0;
        st.out_data  = '0;
        st.out_last  = 1'b0;
        case (state_q)
            StOpen: read_open = ch_onehot;
            StHdr: begin
                st.out_valid = 1'b1;
                st.out_data  = hdr_word(seq_q, ch_q);
            end
            StData: begin
                st.out_valid = 1'b1;
                st.out_data  = snap_data_q;
            end
            StTime: begin
                st.out_valid = 1'b1;
                st.out_data  = snap_time_q;
                st.out_last  = (pending_q == '0);
            end
            default: ;
        endcase
    end

    assign busy       = (state_q != StIdle);
    assign scan_count = count_q;
    assign overrun    = ovr_q;

endmodule

// File: tb/tb_counter_scan_ctrl.sv
// Bench for counter_scan_ctrl: directed scenarios plus random traffic, all checked
// against a record-level reference model evaluated on every falling clock edge.
module tb_counter_scan_ctrl;

    localparam int unsigned N_CH     = 4;
    localparam int unsigned READ_LAT = 4;

    logic                 clk = 1'b0;
    logic                 res_n;
    logic                 scan_start;
    logic                 auto_en;
    logic [31:0]          scan_period;
    logic [N_CH-1:0]      ch_mask;
    logic [N_CH-1:0]      read_open;
    logic [N_CH*32-1:0]   data_ex;
    logic [N_CH*32-1:0]   counter_time_ex;
    logic                 busy;
    logic [15:0]          scan_count;
    logic                 overrun;

    counter_scan_ctrl_if st_if ();

    counter_scan_ctrl #(
        .N_CH     (N_CH),
        .READ_LAT (READ_LAT)
    ) dut (
        .clk             (clk),
        .res_n           (res_n),
        .scan_start      (scan_start),
        .auto_en         (auto_en),
        .scan_period     (scan_period),
        .ch_mask         (ch_mask),
        .read_open       (read_open),
        .data_ex         (data_ex),
        .counter_time_ex (counter_time_ex),
        .st              (st_if),
        .busy            (busy),
        .scan_count      (scan_count),
        .overrun         (overrun)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, req);
    endtask

    // Reference model: a scan is a list of expected words queued when a trigger is accepted.
    typedef struct packed {
        logic [31:0] d;
        logic        last;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] obs_d[$];
    logic        obs_last[$];
    int          rises[$];
    bit          m_busy = 0;
    bit          m_done = 0;
    bit          m_ovr  = 0;
    logic [15:0] m_count = '0;
    logic [N_CH-1:0] m_mask = '0;
    int unsigned elapsed = 0;
    int          cyc = 0;
    bit          stall_prev = 0;
    logic [31:0] prev_data = '0;
    logic        prev_last = 1'b0;
    bit          prev_busy = 0;
    int          run_len [N_CH];

    always @(negedge clk) begin : cmp
        bit busy_now;
        bit tick_m;
        bit trig_m;
        bit hs;
        int lastch;
        if (!res_n) begin
            chk("reset_outputs", {read_open, st_if.out_valid, st_if.out_last, busy, overrun,
                                  scan_count, st_if.out_data}, 64'd0);
            exp_q.delete();
            m_busy = 0; m_done = 0; m_ovr = 0; m_count = '0; m_mask = '0;
            elapsed = 0; stall_prev = 0; prev_busy = 0;
            for (int i = 0; i < N_CH; i++) run_len[i] = 0;
        end else begin
            chk("busy", busy, m_busy);
            chk("scan_count", scan_count, m_count);
            chk("overrun", overrun, m_ovr);
            if (stall_prev) begin
                chk("stall_valid", st_if.out_valid, 1'b1);
                chk("stall_word", {st_if.out_last, st_if.out_data}, {prev_last, prev_data});
            end
            if (exp_q.size() == 0) begin
                chk("idle_valid", st_if.out_valid, 1'b0);
            end else if (st_if.out_valid) begin
                chk("word", st_if.out_data, exp_q[0].d);
                chk("last", st_if.out_last, exp_q[0].last);
            end
            if (!m_busy) chk("open_idle", read_open, '0);
            else chk("open_in_mask", read_open & ~m_mask, '0);
            chk("open_single", $countones(read_open) <= 1, 1'b1);
            for (int i = 0; i < N_CH; i++) begin
                if (read_open[i]) run_len[i]++;
                else begin
                    if (run_len[i] != 0) chk("open_len", run_len[i], READ_LAT);
                    run_len[i] = 0;
                end
            end
            if (busy && !prev_busy) rises.push_back(cyc);
            prev_busy  = busy;
            stall_prev = st_if.out_valid && !st_if.out_ready;
            prev_data  = st_if.out_data;
            prev_last  = st_if.out_last;

            busy_now = m_busy;
            if (m_done) begin
                m_done = 0;
                m_busy = 0;
                m_count++;
            end
            hs = st_if.out_valid && st_if.out_ready;
            if (hs) begin
                obs_d.push_back(st_if.out_data);
                obs_last.push_back(st_if.out_last);
                if (exp_q.size() != 0) begin
                    if (exp_q[0].last) m_done = 1;
                    exp_q.delete(0);
                end
            end
            tick_m = auto_en && (scan_period != 0) && (elapsed != 0) &&
                     ((elapsed % scan_period) == 0);
            if (auto_en && (scan_period != 0)) elapsed++;
            else elapsed = 0;
            trig_m = scan_start || tick_m;
            if (trig_m && busy_now) begin
                m_ovr = 1;
            end else if (trig_m && (ch_mask != '0)) begin
                m_busy = 1;
                m_mask = ch_mask;
                lastch = 0;
                for (int i = 0; i < N_CH; i++) if (ch_mask[i]) lastch = i;
                for (int i = 0; i < N_CH; i++) begin
                    if (ch_mask[i]) begin
                        exp_q.push_back('{d: {8'hC5, m_count[7:0], 8'(i), 8'h00}, last: 1'b0});
                        exp_q.push_back('{d: data_ex[i*32 +: 32], last: 1'b0});
                        exp_q.push_back('{d: counter_time_ex[i*32 +: 32], last: (i == lastch)});
                    end
                end
            end
        end
        cyc++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        res_n = 1'b0;
        step();
        step();
        res_n = 1'b1;
        obs_d.delete();
        obs_last.delete();
        rises.delete();
    endtask

    task automatic pulse_start();
        scan_start = 1'b1;
        step();
        scan_start = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int k;
        k = 0;
        while ((busy || m_busy || exp_q.size() != 0) && k < budget) begin
            step();
            k++;
        end
        chk("idle_in_time", busy || m_busy || (exp_q.size() != 0), 1'b0);
    endtask

    task automatic load_ref_data();
        data_ex = '0;
        counter_time_ex = '0;
        data_ex[31:0] = 32'h11;
        data_ex[95:64] = 32'h22;
        counter_time_ex[31:0] = 32'h100;
        counter_time_ex[95:64] = 32'h200;
        ch_mask = 4'b0101;
    endtask

    logic [31:0] exp_ref [6] = '{32'hC5000000, 32'h11, 32'h100, 32'hC5000200, 32'h22, 32'h200};

    task automatic check_ref_record(input string tag);
        chk({tag, "_nwords"}, obs_d.size(), 6);
        for (int i = 0; i < 6; i++) begin
            if (i < obs_d.size()) begin
                chk({tag, "_word"}, obs_d[i], exp_ref[i]);
                chk({tag, "_last"}, obs_last[i], i == 5);
            end
        end
    endtask

    initial begin
        int en_cyc;
        res_n = 1'b0;
        scan_start = 1'b0;
        auto_en = 1'b0;
        scan_period = '0;
        ch_mask = '0;
        data_ex = '0;
        counter_time_ex = '0;
        st_if.out_ready = 1'b0;
        step();
        step();
        chk("rst_busy", busy, 1'b0);
        chk("rst_read_open", read_open, '0);
        chk("rst_valid", st_if.out_valid, 1'b0);
        chk("rst_count", scan_count, 16'd0);
        chk("rst_overrun", overrun, 1'b0);
        res_n = 1'b1;
        step();

        // Reference record, sink always ready.
        do_reset();
        load_ref_data();
        st_if.out_ready = 1'b1;
        pulse_start();
        wait_idle(200);
        check_ref_record("ref");
        chk("ref_count", scan_count, 16'd1);

        // Same record with the sink stalling every other cycle.
        do_reset();
        load_ref_data();
        st_if.out_ready = 1'b0;
        pulse_start();
        for (int k = 0; k < 200 && (busy || exp_q.size() != 0); k++) begin
            st_if.out_ready = ~st_if.out_ready;
            step();
        end
        st_if.out_ready = 1'b1;
        wait_idle(50);
        check_ref_record("stall");

        // Empty mask: trigger ignored.
        do_reset();
        ch_mask = '0;
        pulse_start();
        repeat (20) step();
        chk("nomask_words", obs_d.size(), 0);
        chk("nomask_count", scan_count, 16'd0);

        // Trigger while busy is dropped and flagged.
        do_reset();
        load_ref_data();
        pulse_start();
        repeat (3) step();
        pulse_start();
        wait_idle(200);
        chk("ovr_flag", overrun, 1'b1);
        chk("ovr_words", obs_d.size(), 6);
        chk("ovr_count", scan_count, 16'd1);

        // scan_start coinciding with a timer tick gives one scan.
        do_reset();
        load_ref_data();
        scan_period = 32'd50;
        auto_en = 1'b1;
        repeat (50) step();
        pulse_start();
        repeat (25) step();
        auto_en = 1'b0;
        wait_idle(200);
        chk("coinc_count", scan_count, 16'd1);
        chk("coinc_overrun", overrun, 1'b0);
        chk("coinc_words", obs_d.size(), 6);

        // Periodic scanning every 100 cycles.
        do_reset();
        load_ref_data();
        scan_period = 32'd100;
        en_cyc = cyc;
        auto_en = 1'b1;
        repeat (320) step();
        auto_en = 1'b0;
        wait_idle(200);
        chk("auto_nscans", rises.size(), 3);
        for (int k = 0; k < 3; k++) begin
            if (k < rises.size()) chk("auto_trig_cycle", rises[k] - en_cyc - 1, 100 * (k + 1));
        end
        chk("auto_nwords", obs_d.size(), 18);
        if (obs_d.size() == 18) begin
            chk("auto_seq0", obs_d[0][23:16], 8'd0);
            chk("auto_seq1", obs_d[6][23:16], 8'd1);
            chk("auto_seq2", obs_d[12][23:16], 8'd2);
        end
        chk("auto_count", scan_count, 16'd3);

        // Reset in the middle of channel 2's read window.
        do_reset();
        load_ref_data();
        pulse_start();
        wait_idle(200);
        chk("abort_pre_count", scan_count, 16'd1);
        pulse_start();
        for (int k = 0; k < 100 && !read_open[2]; k++) step();
        chk("abort_open2", read_open[2], 1'b1);
        step();
        res_n = 1'b0;
        #1;
        chk("abort_read_open", read_open, '0);
        chk("abort_outputs", {st_if.out_valid, st_if.out_last, busy, overrun, scan_count,
                              st_if.out_data}, 64'd0);
        step();
        step();
        res_n = 1'b1;
        obs_d.delete();
        obs_last.delete();
        repeat (20) step();
        chk("abort_silent", obs_d.size(), 0);
        pulse_start();
        wait_idle(200);
        chk("abort_next_hdr", obs_d.size() > 0 ? obs_d[0] : 32'hFFFF_FFFF, 32'hC5000000);
        chk("abort_next_count", scan_count, 16'd1);

        // Random traffic.
        do_reset();
        for (int k = 0; k < 3000; k++) begin
            if (k % 500 == 0) begin
                auto_en = 1'b0;
            end else if (k % 500 == 1) begin
                scan_period = $urandom_range(60, 0);
                auto_en = 1'($urandom_range(1, 0));
            end
            ch_mask = 4'($urandom);
            st_if.out_ready = ($urandom_range(3, 0) != 0);
            scan_start = ($urandom_range(39, 0) == 0);
            if (!busy) begin
                for (int i = 0; i < N_CH; i++) begin
                    data_ex[i*32 +: 32] = $urandom;
                    counter_time_ex[i*32 +: 32] = $urandom;
                end
            end
            step();
        end
        scan_start = 1'b0;
        auto_en = 1'b0;
        st_if.out_ready = 1'b1;
        wait_idle(500);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
